// File: rtl/spi_fl_seq_pkg.sv
// rtl/spi_fl_seq_pkg.sv - shared codes and state encodings for the SPI flash sequencer
package spi_fl_seq_pkg;

  typedef enum logic [1:0] {
    OP_READ    = 2'd0,
    OP_STATUS  = 2'd1,
    OP_PROGRAM = 2'd2,
    OP_ERASE   = 2'd3
  } op_e;

  localparam logic [2:0] CT_CMD     = 3'd0;
  localparam logic [2:0] CT_ADDR    = 3'd1;
  localparam logic [2:0] CT_ADDR_TX = 3'd2;
  localparam logic [2:0] CT_ADDR_RX = 3'd3;
  localparam logic [2:0] CT_RX      = 3'd4;

  localparam logic [7:0] OPC_WREN   = 8'h06;
  localparam logic [7:0] OPC_RDSR   = 8'h05;
  localparam logic [7:0] OPC_READ3  = 8'h03;
  localparam logic [7:0] OPC_FREAD3 = 8'h0B;
  localparam logic [7:0] OPC_READ4  = 8'h13;
  localparam logic [7:0] OPC_FREAD4 = 8'h0C;
  localparam logic [7:0] OPC_PP3    = 8'h02;
  localparam logic [7:0] OPC_PP4    = 8'h12;
  localparam logic [7:0] OPC_SE3    = 8'hD8;
  localparam logic [7:0] OPC_SE4    = 8'hDC;

  // Program/erase step 2 is the busy poll; it repeats without advancing.
  localparam logic [1:0] STEP_POLL = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE   = 3'd1,
    S_WAIT_LO = 3'd2,
    S_WAIT_HI = 3'd3,
    S_STEP    = 3'd4,
    S_DONE    = 3'd5
  } state_e;

endpackage

// File: rtl/spi_fl_step_dec.sv
// rtl/spi_fl_step_dec.sv - maps (op, step) to the master transaction fields
module spi_fl_step_dec
  import spi_fl_seq_pkg::*;
#(
  parameter bit FAST_READ = 1'b1,
  parameter bit ADDR4B    = 1'b1
) (
  input  logic [1:0] op_i,
  input  logic [1:0] step_i,
  output logic [7:0] command_o,
  output logic [2:0] commtype_o,
  output logic [6:0] ndata_bits_o,
  output logic [3:0] dummy_cycles_o
);

  always_comb begin
    command_o      = OPC_RDSR;
    commtype_o     = CT_RX;
    ndata_bits_o   = 7'd8;
    dummy_cycles_o = 4'd0;
    if (op_i == OP_READ) begin
      if (ADDR4B) command_o = FAST_READ ? OPC_FREAD4 : OPC_READ4;
      else        command_o = FAST_READ ? OPC_FREAD3 : OPC_READ3;
      commtype_o     = CT_ADDR_RX;
      ndata_bits_o   = 7'd32;
      dummy_cycles_o = FAST_READ ? 4'd8 : 4'd0;
    end else if (op_i != OP_STATUS) begin
      case (step_i)
        2'd0: begin
          command_o    = OPC_WREN;
          commtype_o   = CT_CMD;
          ndata_bits_o = 7'd0;
        end
        2'd1: begin
          if (op_i == OP_PROGRAM) begin
            command_o    = ADDR4B ? OPC_PP4 : OPC_PP3;
            commtype_o   = CT_ADDR_TX;
            ndata_bits_o = 7'd32;
          end else begin
            command_o    = ADDR4B ? OPC_SE4 : OPC_SE3;
            commtype_o   = CT_ADDR;
            ndata_bits_o = 7'd0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/spi_fl_seq.sv
// rtl/spi_fl_seq.sv - turns word-level flash requests into ordered spi_master_fl transactions
module spi_fl_seq
  import spi_fl_seq_pkg::*;
#(
  parameter bit FAST_READ = 1'b1,
  parameter bit ADDR4B    = 1'b1,
  parameter int POLL_MAX  = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [7:0]  command,
  output logic [31:0] address,
  output logic [31:0] data_in,
  output logic [2:0]  commtype,
  output logic [6:0]  ndata_bits,
  output logic [3:0]  dummy_cycles,
  output logic [9:0]  frame_struct,
  output logic [1:0]  xipbit_en,
  output logic [1:0]  spimode,
  output logic        dtr_en,
  output logic        fourbyteaddr_on,
  output logic        validflag,
  input  logic        tready,
  input  logic [31:0] data_out
);

  localparam int PW = $clog2(POLL_MAX + 1);

  state_e      state_q, state_d;
  logic [1:0]  op_q, op_d, step_q, step_d;
  logic [PW-1:0] poll_q, poll_d;
  logic [7:0]  command_q, command_d;
  logic [31:0] address_q, address_d, data_in_q, data_in_d;
  logic [2:0]  commtype_q, commtype_d;
  logic [6:0]  ndata_q, ndata_d;
  logic [3:0]  dummy_q, dummy_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d, load;

  logic [1:0]  dec_op, dec_step;
  logic [7:0]  dec_command;
  logic [2:0]  dec_commtype;
  logic [6:0]  dec_ndata;
  logic [3:0]  dec_dummy;

  // Decoder looks at the step about to be issued so fields are registered on entry to ISSUE.
  assign dec_op   = (state_q == S_IDLE) ? req_op : op_q;
  assign dec_step = (state_q == S_IDLE) ? 2'd0 :
                    ((step_q == STEP_POLL) ? STEP_POLL : step_q + 2'd1);

  spi_fl_step_dec #(.FAST_READ(FAST_READ), .ADDR4B(ADDR4B)) u_dec (
    .op_i          (dec_op),
    .step_i        (dec_step),
    .command_o     (dec_command),
    .commtype_o    (dec_commtype),
    .ndata_bits_o  (dec_ndata),
    .dummy_cycles_o(dec_dummy)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      op_q       <= 2'd0;
      step_q     <= 2'd0;
      poll_q     <= '0;
      command_q  <= 8'd0;
      address_q  <= 32'd0;
      data_in_q  <= 32'd0;
      commtype_q <= CT_CMD;
      ndata_q    <= 7'd0;
      dummy_q    <= 4'd0;
      rdata_q    <= 32'd0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      step_q     <= step_d;
      poll_q     <= poll_d;
      command_q  <= command_d;
      address_q  <= address_d;
      data_in_q  <= data_in_d;
      commtype_q <= commtype_d;
      ndata_q    <= ndata_d;
      dummy_q    <= dummy_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    step_d     = step_q;
    poll_d     = poll_q;
    command_d  = command_q;
    address_d  = address_q;
    data_in_d  = data_in_q;
    commtype_d = commtype_q;
    ndata_d    = ndata_q;
    dummy_d    = dummy_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    load       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          op_d      = req_op;
          step_d    = 2'd0;
          address_d = req_addr;
          data_in_d = req_wdata;
          load      = 1'b1;
          state_d   = S_ISSUE;
        end
      end
      S_ISSUE:   if (tready)  state_d = S_WAIT_LO;
      S_WAIT_LO: if (!tready) state_d = S_WAIT_HI;
      S_WAIT_HI: if (tready)  state_d = S_STEP;
      S_STEP: begin
        state_d = S_ISSUE;
        if (op_q == OP_READ) begin
          rdata_d = data_out;
          err_d   = 1'b0;
          state_d = S_DONE;
        end else if (op_q == OP_STATUS) begin
          rdata_d = {24'h0, data_out[7:0]};
          err_d   = 1'b0;
          state_d = S_DONE;
        end else if (step_q == STEP_POLL) begin
          rdata_d = {24'h0, data_out[7:0]};
          if (!data_out[0]) begin
            err_d   = 1'b0;
            state_d = S_DONE;
          end else begin
            poll_d = poll_q + PW'(1);
            if (poll_d == PW'(POLL_MAX)) begin
              err_d   = 1'b1;
              state_d = S_DONE;
            end else begin
              load = 1'b1;
            end
          end
        end else begin
          step_d = step_q + 2'd1;
          load   = 1'b1;
        end
      end
      S_DONE: begin
        poll_d  = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (load) begin
      command_d  = dec_command;
      commtype_d = dec_commtype;
      ndata_d    = dec_ndata;
      dummy_d    = dec_dummy;
    end
  end

  assign req_ready       = (state_q == S_IDLE);
  assign resp_valid      = (state_q == S_DONE);
  assign validflag       = (state_q == S_ISSUE) && tready;
  assign resp_rdata      = rdata_q;
  assign resp_err        = err_q;
  assign command         = command_q;
  assign address         = address_q;
  assign data_in         = data_in_q;
  assign commtype        = commtype_q;
  assign ndata_bits      = ndata_q;
  assign dummy_cycles    = dummy_q;
  assign frame_struct    = 10'd0;
  assign xipbit_en       = 2'd0;
  assign spimode         = 2'd0;
  assign dtr_en          = 1'b0;
  assign fourbyteaddr_on = ADDR4B;

endmodule

// File: tb/tb_spi_fl_seq.sv
// tb/tb_spi_fl_seq.sv - randomized bench for spi_fl_seq against a transaction-list model
module tb_spi_fl_seq;
  import spi_fl_seq_pkg::*;

  localparam int POLL_MAX = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0, tready = 1'b1;
  logic [1:0]  req_op = 2'd0;
  logic [31:0] req_addr = '0, req_wdata = '0, data_out = '0;
  logic        req_ready, resp_valid, resp_err, dtr_en, fourbyteaddr_on, validflag;
  logic [31:0] resp_rdata, address, data_in;
  logic [7:0]  command;
  logic [2:0]  commtype;
  logic [6:0]  ndata_bits;
  logic [3:0]  dummy_cycles;
  logic [9:0]  frame_struct;
  logic [1:0]  xipbit_en, spimode;

  always #5 clk = ~clk;

  spi_fl_seq #(.FAST_READ(1'b1), .ADDR4B(1'b1), .POLL_MAX(POLL_MAX)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .command(command), .address(address),
    .data_in(data_in), .commtype(commtype), .ndata_bits(ndata_bits),
    .dummy_cycles(dummy_cycles), .frame_struct(frame_struct), .xipbit_en(xipbit_en),
    .spimode(spimode), .dtr_en(dtr_en), .fourbyteaddr_on(fourbyteaddr_on),
    .validflag(validflag), .tready(tready), .data_out(data_out)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  logic [7:0]  t_cmd[$];
  logic [13:0] t_fld[$];
  logic [31:0] t_addr[$], t_din[$];
  logic [7:0]  stat_q[$];
  int          sidx, n_resp, ready_leaks, early_vf, first_vf;
  logic [31:0] r_rdata;
  logic        r_err;

  function automatic logic [7:0] stat_at(input int i);
    return (i < stat_q.size()) ? stat_q[i] : stat_q[stat_q.size()-1];
  endfunction

  function automatic logic [13:0] fields_of(input logic [7:0] cmd);
    case (cmd)
      8'h06:   return {CT_CMD,     7'd0,  4'd0};
      8'h0C:   return {CT_ADDR_RX, 7'd32, 4'd8};
      8'h12:   return {CT_ADDR_TX, 7'd32, 4'd0};
      8'hDC:   return {CT_ADDR,    7'd0,  4'd0};
      8'h05:   return {CT_RX,      7'd8,  4'd0};
      default: return '1;
    endcase
  endfunction

  task automatic chk_reset(input string tag);
    chk({tag, ".validflag"}, 32'(validflag), 32'd0);
    chk({tag, ".resp_valid"}, 32'(resp_valid), 32'd0);
    chk({tag, ".resp_err"}, 32'(resp_err), 32'd0);
    chk({tag, ".resp_rdata"}, resp_rdata, 32'd0);
    chk({tag, ".command"}, 32'(command), 32'd0);
    chk({tag, ".address"}, address, 32'd0);
    chk({tag, ".data_in"}, data_in, 32'd0);
    chk({tag, ".fields"}, 32'({commtype, ndata_bits, dummy_cycles}), 32'({CT_CMD, 11'd0}));
    chk({tag, ".req_ready"}, 32'(req_ready), 32'd1);
  endtask

  // Acts as spi_master_fl: accepts a validflag, drops tready for a few cycles, returns data.
  task automatic run_op(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] rd_word, input int stall, input bit hold_valid,
                        input bit abort_pp);
    int phase = 0;
    int cnt = 0;
    t_cmd.delete(); t_fld.delete(); t_addr.delete(); t_din.delete();
    sidx = 0; n_resp = 0; ready_leaks = 0; early_vf = 0; first_vf = -1;
    @(negedge clk);
    tready = (stall == 0); req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wdata;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      if (!hold_valid) req_valid = 1'b0;
      if (stall > 0) begin
        stall--;
        if (stall == 0) tready = 1'b1;
      end
      #1;
      if (validflag && !tready) early_vf++;
      if (req_ready) ready_leaks++;
      if (resp_valid) begin
        n_resp++; r_rdata = resp_rdata; r_err = resp_err; req_valid = 1'b0;
        break;
      end
      case (phase)
        0: if (validflag) begin
          if (first_vf < 0) first_vf = cyc;
          t_cmd.push_back(command);
          t_fld.push_back({commtype, ndata_bits, dummy_cycles});
          t_addr.push_back(address);
          t_din.push_back(data_in);
          phase = 1;
        end
        1: begin
          tready = 1'b0; cnt = int'($urandom_range(1, 4)); phase = 2;
        end
        default: begin
          if (abort_pp && t_cmd.size() == 2) begin
            rst = 1'b0;
            #1 chk_reset("abort");
            @(negedge clk);
            rst = 1'b1; tready = 1'b1; req_valid = 1'b0;
            return;
          end
          cnt--;
          if (cnt == 0) begin
            if (t_cmd[$] == 8'h05) begin
              data_out = {(op == OP_STATUS) ? 24'($urandom) : 24'h0, stat_at(sidx)};
              sidx++;
            end else if (t_cmd[$] == 8'h0C) data_out = rd_word;
            else data_out = $urandom;
            tready = 1'b1; phase = 0;
          end
        end
      endcase
    end
    repeat (4) begin
      @(negedge clk); #1;
      if (resp_valid) n_resp++;
    end
  endtask

  task automatic expect_op(input string tag, input logic [1:0] op, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] rd_word, input int stall);
    logic [7:0] exp_cmd[$];
    logic [7:0] last = 8'h00;
    bit e_err = 1'b0;
    int npoll = 0;
    if (op == OP_READ) exp_cmd.push_back(8'h0C);
    else if (op == OP_STATUS) exp_cmd.push_back(8'h05);
    else begin
      exp_cmd.push_back(8'h06);
      exp_cmd.push_back((op == OP_PROGRAM) ? 8'h12 : 8'hDC);
      while (npoll < 100) begin
        last = stat_at(npoll);
        npoll++;
        exp_cmd.push_back(8'h05);
        if (!last[0]) break;
        if (npoll == POLL_MAX) begin e_err = 1'b1; break; end
      end
    end
    chk({tag, ".ntxn"}, 32'(t_cmd.size()), 32'(exp_cmd.size()));
    for (int i = 0; i < exp_cmd.size() && i < t_cmd.size(); i++) begin
      chk($sformatf("%s.cmd%0d", tag, i), 32'(t_cmd[i]), 32'(exp_cmd[i]));
      chk($sformatf("%s.fld%0d", tag, i), 32'(t_fld[i]), 32'(fields_of(exp_cmd[i])));
      if (exp_cmd[i] inside {8'h0C, 8'h12, 8'hDC})
        chk($sformatf("%s.addr%0d", tag, i), t_addr[i], addr);
      if (exp_cmd[i] == 8'h12) chk($sformatf("%s.din%0d", tag, i), t_din[i], wdata);
    end
    chk({tag, ".nresp"}, 32'(n_resp), 32'd1);
    chk({tag, ".err"}, 32'(r_err), 32'(e_err));
    if (op == OP_READ) chk({tag, ".rdata"}, r_rdata, rd_word);
    else if (op == OP_STATUS) chk({tag, ".rdata"}, r_rdata, {24'h0, stat_q[0]});
    else if (e_err) chk({tag, ".rdata"}, r_rdata, {24'h0, last});
    chk({tag, ".ready_leak"}, 32'(ready_leaks), 32'd0);
    chk({tag, ".early_vf"}, 32'(early_vf), 32'd0);
    chk({tag, ".vf_latency"}, 32'(first_vf), 32'((stall == 0) ? 0 : stall - 1));
  endtask

  initial begin
    repeat (2) @(negedge clk);
    #1 chk_reset("por");
    chk("por.const", 32'({frame_struct, xipbit_en, spimode, dtr_en}), 32'd0);
    chk("por.4b", 32'(fourbyteaddr_on), 32'd1);
    rst = 1'b1;

    stat_q = '{8'h00};
    run_op(OP_READ, 32'h00A5_5A11, 32'h0, 32'hA0A0_A0A3, 0, 1'b0, 1'b0);
    expect_op("rd", OP_READ, 32'h00A5_5A11, 32'h0, 32'hA0A0_A0A3, 0);

    stat_q = '{8'h01, 8'h01, 8'h01, 8'h00};
    run_op(OP_PROGRAM, 32'h100, 32'hAABB_CCDD, 32'h0, 0, 1'b0, 1'b0);
    expect_op("pp", OP_PROGRAM, 32'h100, 32'hAABB_CCDD, 32'h0, 0);

    stat_q = '{8'h03};
    run_op(OP_ERASE, 32'h0001_0000, 32'h0, 32'h0, 0, 1'b0, 1'b0);
    expect_op("se_to", OP_ERASE, 32'h0001_0000, 32'h0, 32'h0, 0);

    stat_q = '{8'h5A};
    run_op(OP_STATUS, 32'h0, 32'h0, 32'h0, 50, 1'b0, 1'b0);
    expect_op("st_stall", OP_STATUS, 32'h0, 32'h0, 32'h0, 50);

    stat_q = '{8'h01, 8'h00};
    run_op(OP_PROGRAM, 32'h200, 32'h1234_5678, 32'h0, 0, 1'b0, 1'b1);
    stat_q = '{8'h00};
    run_op(OP_READ, 32'h0000_0040, 32'h0, 32'h5555_AAAA, 0, 1'b0, 1'b0);
    expect_op("rd_post", OP_READ, 32'h0000_0040, 32'h0, 32'h5555_AAAA, 0);

    stat_q = '{8'h01, 8'h00};
    run_op(OP_PROGRAM, 32'h300, 32'hCAFE_F00D, 32'h0, 0, 1'b1, 1'b0);
    expect_op("pp_hold", OP_PROGRAM, 32'h300, 32'hCAFE_F00D, 32'h0, 0);

    for (int n = 0; n < 24; n++) begin
      logic [1:0]  op;
      logic [31:0] a, w, r;
      int busy, st;
      op = 2'($urandom_range(0, 3));
      a = $urandom; w = $urandom; r = $urandom;
      busy = int'($urandom_range(0, 5));
      st = int'($urandom_range(0, 3));
      stat_q.delete();
      for (int i = 0; i < busy; i++) stat_q.push_back(8'($urandom_range(0, 255)) | 8'h01);
      stat_q.push_back(8'($urandom_range(0, 255)) & 8'hFE);
      if (op == OP_STATUS) stat_q[0] = 8'($urandom_range(0, 255));
      run_op(op, a, w, r, st, 1'($urandom_range(0, 1)), 1'b0);
      expect_op($sformatf("rnd%0d", n), op, a, w, r, st);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
